watchdog_reset_sequencer: RTL and testbench
===========================================

// Module: watchdog_reset_sequencer
// PURPOSE
//   Consumes the watchdog error flag and turns it into a controlled system reset.
//   On error: asserts a timed reset, restarts the watchdog, then allows a boot grace window.
//   Counts consecutive failed boots. After Max_Retries, holds the system in lockout until cleared.
//   Sits between the watchdog and the system reset tree.
// PARAMETERS
//   Clk_Frequency  50_000_000  ipClk frequency, Hz
//   Hold_ms        10          system reset pulse length, ms
//   Grace_ms       200         post-reset window where watchdog error is ignored, ms
//   Stable_ms      1000        error-free run time that clears the retry count, ms
//   Max_Retries    3           consecutive watchdog resets before lockout (>=1)
// PORTS
//   ipClk              in   1     system clock
//   ipnReset           in   1     asynchronous, active-low reset
//   ipWatchdogError    in   1     watchdog timeout flag, level, synchronous to ipClk
//   ipClearLockout     in   1     level; releases LOCKOUT
//   opSystemReset      out  1     active-high reset to downstream logic
//   opWatchdogRestart  out  1     reloads the watchdog; high throughout HOLD
//   opLockout          out  1     high in LOCKOUT
//   opRetryCount       out  RW    consecutive watchdog resets; RW = $clog2(Max_Retries+1)
// BEHAVIOUR
//   - Cycles(x_ms) = (Clk_Frequency/1000)*x_ms.
//   - Single down-counter, width $clog2(max of the three cycle counts)+1. Loaded on each state entry.
//   - Async reset (ipnReset=0) gives:
//     - state = HOLD, counter = Cycles(Hold_ms)-1, opRetryCount = 0.
//     - opSystemReset = 1, opWatchdogRestart = 1, opLockout = 0.
//     - Power-on therefore produces one full reset pulse.
//   - States and transitions:
//     - HOLD: opSystemReset=1, opWatchdogRestart=1. When counter==0 -> GRACE.
//     - GRACE: outputs 0. ipWatchdogError ignored. When counter==0 -> ARMED.
//     - ARMED: outputs 0. Counter runs Cycles(Stable_ms).
//       - Counter reaching 0 clears opRetryCount. Stays ARMED; counter does not reload.
//       - ipWatchdogError=1: if opRetryCount==Max_Retries-1 -> LOCKOUT; else opRetryCount+1 -> HOLD.
//     - LOCKOUT: opSystemReset=1, opLockout=1, opWatchdogRestart=1, opRetryCount=Max_Retries.
//       - ipClearLockout=1 -> HOLD and opRetryCount=0.
//   - HOLD and GRACE last exactly Cycles(x) clock cycles.
//   - Error -> opSystemReset high latency: 1 cycle (registered).
//   - All outputs registered; no combinational path from inputs.
//   - Simultaneous events:
//     - ARMED: error and stable-expiry on the same cycle -> error wins; the count still increments.
//     - ipClearLockout outside LOCKOUT: ignored.
//     - Error held high across GRACE end: acted on in the first ARMED cycle.
//   - opRetryCount saturates; it never wraps.
//   - ipnReset mid-operation: immediate return to the reset values.
// CONFIGURATION
//   WDT_RESET_CAUSE_EN defined:
//     - Adds port opResetCause out 2: 00 power-on, 01 watchdog, 10 lockout-cleared.
//     - Updated on every HOLD entry; reset value 00.
//   Undefined: port absent, no cause logic.
// STRUCTURE
//   Package wdt_seq_pkg holds:
//     - state enum {HOLD, GRACE, ARMED, LOCKOUT}
//     - cause encodings
//     - function ms_to_cycles(freq, ms)
//   Sub-module cycle_timer: loadable down-counter with zero flag, width parameter.
// TESTING  (Clk_Frequency=1000, Hold=4, Grace=8, Stable=16, Max_Retries=2)
//   1. Release ipnReset -> opSystemReset high exactly 4 cycles, then 8 GRACE cycles, then ARMED.
//   2. Error in GRACE cycle 3 -> ignored; the block reaches ARMED on schedule.
//   3. Error in ARMED -> opSystemReset high the next cycle for 4 cycles; opRetryCount=1.
//   4. Second error before 16 stable cycles -> LOCKOUT, opLockout=1, opRetryCount=2.
//      Pulse ipClearLockout -> HOLD, count 0.
//   5. One error, then 16 error-free ARMED cycles -> opRetryCount returns to 0.
//   6. ipnReset low mid-HOLD and mid-LOCKOUT -> all outputs at reset values asynchronously.
//      With WDT_RESET_CAUSE_EN defined, check opResetCause = 00/01/10 per HOLD entry.

Source files
------------

// File: rtl/wdt_seq_pkg.sv
// Shared types and helpers for the watchdog reset sequencer.
package wdt_seq_pkg;

    // Sequencer phases: timed reset, boot grace, supervised run, latched failure.
    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StGrace   = 2'd1,
        StArmed   = 2'd2,
        StLockout = 2'd3
    } wdt_state_e;

    // Why the most recent reset pulse was issued.
    typedef enum logic [1:0] {
        CausePowerOn    = 2'b00,
        CauseWatchdog   = 2'b01,
        CauseLockoutClr = 2'b10
    } reset_cause_e;

    // Number of clock cycles in a period given in milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
        return (freq / 1000) * ms;
    endfunction

    // Largest of three cycle counts; sizes the shared down-counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag. Holds at zero until reloaded.
module cycle_timer #(
    parameter int unsigned      Width    = 8,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             ipClk,
    input  logic             ipnReset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    // Load takes priority; otherwise count down and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    // Counter register; reset value is chosen by the parent.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            count_q <= ResetVal;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/watchdog_reset_sequencer.sv
// Watchdog reset sequencer: turns a watchdog timeout into a timed system reset,
// a post-boot grace window, and a lockout after too many consecutive failed boots.
// Optional feature: define WDT_RESET_CAUSE_EN to add the opResetCause output.
module watchdog_reset_sequencer
    import wdt_seq_pkg::*;
#(
    parameter int unsigned Clk_Frequency = 50_000_000,
    parameter int unsigned Hold_ms       = 10,
    parameter int unsigned Grace_ms      = 200,
    parameter int unsigned Stable_ms     = 1000,
    parameter int unsigned Max_Retries   = 3
) (
    input  logic                                 ipClk,
    input  logic                                 ipnReset,
    input  logic                                 ipWatchdogError,
    input  logic                                 ipClearLockout,
    output logic                                 opSystemReset,
    output logic                                 opWatchdogRestart,
    output logic                                 opLockout,
`ifdef WDT_RESET_CAUSE_EN
    output logic [1:0]                           opResetCause,
`endif
    output logic [$clog2(Max_Retries + 1)-1:0]   opRetryCount
);

    localparam int unsigned RW           = $clog2(Max_Retries + 1);
    localparam int unsigned HoldCycles   = ms_to_cycles(Clk_Frequency, Hold_ms);
    localparam int unsigned GraceCycles  = ms_to_cycles(Clk_Frequency, Grace_ms);
    localparam int unsigned StableCycles = ms_to_cycles(Clk_Frequency, Stable_ms);
    localparam int unsigned MaxCycles    = max3(HoldCycles, GraceCycles, StableCycles);
    localparam int unsigned CntW         = $clog2(MaxCycles) + 1;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CntW-1:0] HoldLoad   = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GraceLoad  = CntW'(GraceCycles - 1);
    localparam logic [CntW-1:0] StableLoad = CntW'(StableCycles - 1);

    localparam logic [RW-1:0] RetryMax  = RW'(Max_Retries);
    localparam logic [RW-1:0] RetryLast = RW'(Max_Retries - 1);

    wdt_state_e      state_q, state_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            timer_load;
    logic [CntW-1:0] timer_val;
    logic            timer_zero;

    logic            sys_rst_q, sys_rst_d;
    logic            restart_q, restart_d;
    logic            lockout_q, lockout_d;

`ifdef WDT_RESET_CAUSE_EN
    reset_cause_e    cause_q, cause_d;
`endif

    // Shared phase timer; reset value makes power-on produce one full HOLD pulse.
    cycle_timer #(
        .Width    (CntW),
        .ResetVal (HoldLoad)
    ) u_timer (
        .ipClk      (ipClk),
        .ipnReset   (ipnReset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // State and retry-count registers.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state_q <= StHold;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    // Next-state logic; the timer is reloaded on every state entry.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        timer_load = 1'b0;
        timer_val  = '0;
`ifdef WDT_RESET_CAUSE_EN
        cause_d    = cause_q;
`endif
        unique case (state_q)
            StHold: begin
                if (timer_zero) begin
                    state_d    = StGrace;
                    timer_load = 1'b1;
                    timer_val  = GraceLoad;
                end
            end
            StGrace: begin
                // Watchdog error is deliberately ignored while the system boots.
                if (timer_zero) begin
                    state_d    = StArmed;
                    timer_load = 1'b1;
                    timer_val  = StableLoad;
                end
            end
            StArmed: begin
                // Error outranks stable-expiry, so the count still advances that cycle.
                if (ipWatchdogError) begin
                    if (retry_q >= RetryLast) begin
                        state_d    = StLockout;
                        retry_d    = RetryMax;
                        timer_load = 1'b1;
                        timer_val  = '0;
                    end else begin
                        state_d    = StHold;
                        retry_d    = retry_q + RW'(1);
                        timer_load = 1'b1;
                        timer_val  = HoldLoad;
`ifdef WDT_RESET_CAUSE_EN
                        cause_d    = CauseWatchdog;
`endif
                    end
                end else if (timer_zero) begin
                    // Ran long enough without a timeout: the boot counts as good.
                    retry_d = '0;
                end
            end
            StLockout: begin
                retry_d = RetryMax;
                if (ipClearLockout) begin
                    state_d    = StHold;
                    retry_d    = '0;
                    timer_load = 1'b1;
                    timer_val  = HoldLoad;
`ifdef WDT_RESET_CAUSE_EN
                    cause_d    = CauseLockoutClr;
`endif
                end
            end
            default: begin
                state_d    = StHold;
                timer_load = 1'b1;
                timer_val  = HoldLoad;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track state_q exactly.
    always_comb begin
        sys_rst_d = (state_d == StHold) || (state_d == StLockout);
        restart_d = (state_d == StHold) || (state_d == StLockout);
        lockout_d = (state_d == StLockout);
    end

    // Output registers; reset values hold the system in reset from power-on.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            sys_rst_q <= 1'b1;
            restart_q <= 1'b1;
            lockout_q <= 1'b0;
        end else begin
            sys_rst_q <= sys_rst_d;
            restart_q <= restart_d;
            lockout_q <= lockout_d;
        end
    end

`ifdef WDT_RESET_CAUSE_EN
    // Reset cause, updated on each HOLD entry.
    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            cause_q <= CausePowerOn;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign opResetCause = cause_q;
`endif

    assign opSystemReset     = sys_rst_q;
    assign opWatchdogRestart = restart_q;
    assign opLockout         = lockout_q;
    assign opRetryCount      = retry_q;

endmodule

// File: tb/tb_watchdog_reset_sequencer.sv
// Self-checking bench for watchdog_reset_sequencer (small timing parameters).
// Handles both builds: with and without WDT_RESET_CAUSE_EN.
module tb_watchdog_reset_sequencer;

    localparam int unsigned F  = 1000;
    localparam int unsigned H  = 4;
    localparam int unsigned G  = 8;
    localparam int unsigned S  = 16;
    localparam int unsigned MR = 2;
    localparam int unsigned RW = $clog2(MR + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          err;
    logic          clr;
    logic          sys_rst;
    logic          restart;
    logic          lockout;
    logic [RW-1:0] retry;
`ifdef WDT_RESET_CAUSE_EN
    logic [1:0]    cause;
`endif

    always #5 clk = ~clk;

    watchdog_reset_sequencer #(
        .Clk_Frequency (F),
        .Hold_ms       (4),
        .Grace_ms      (8),
        .Stable_ms     (16),
        .Max_Retries   (MR)
    ) dut (
        .ipClk             (clk),
        .ipnReset          (rst_n),
        .ipWatchdogError   (err),
        .ipClearLockout    (clr),
        .opSystemReset     (sys_rst),
        .opWatchdogRestart (restart),
        .opLockout         (lockout),
`ifdef WDT_RESET_CAUSE_EN
        .opResetCause      (cause),
`endif
        .opRetryCount      (retry)
    );

    // Reference model: phase plus cycles spent in it, retry tally, last cause.
    typedef enum int {MHold, MGrace, MArmed, MLock} mphase_e;
    mphase_e m_phase;
    int      m_elapsed;
    int      m_retry;
    int      m_cause;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_phase   = MHold;
        m_elapsed = 0;
        m_retry   = 0;
        m_cause   = 0;
    endtask

    // One clock edge of the behavioural rules, with the inputs seen at that edge.
    task automatic model_step(input bit e, input bit c);
        case (m_phase)
            MHold: begin
                m_elapsed++;
                if (m_elapsed == H) begin m_phase = MGrace; m_elapsed = 0; end
            end
            MGrace: begin
                m_elapsed++;
                if (m_elapsed == G) begin m_phase = MArmed; m_elapsed = 0; end
            end
            MArmed: begin
                if (e) begin
                    if (m_retry + 1 >= MR) begin
                        m_phase = MLock;
                        m_retry = MR;
                    end else begin
                        m_retry   = m_retry + 1;
                        m_phase   = MHold;
                        m_elapsed = 0;
                        m_cause   = 1;
                    end
                end else begin
                    if (m_elapsed >= S - 1) m_retry = 0;
                    m_elapsed++;
                end
            end
            MLock: begin
                if (c) begin
                    m_phase   = MHold;
                    m_elapsed = 0;
                    m_retry   = 0;
                    m_cause   = 2;
                end
            end
            default: m_phase = MHold;
        endcase
    endtask

    task automatic check_all(input string tag);
        bit in_rst;
        in_rst = (m_phase == MHold) || (m_phase == MLock);
        check($sformatf("%s.sysrst", tag), 32'(sys_rst), 32'(in_rst));
        check($sformatf("%s.restart", tag), 32'(restart), 32'(in_rst));
        check($sformatf("%s.lockout", tag), 32'(lockout), 32'(m_phase == MLock));
        check($sformatf("%s.retry", tag), 32'(retry), 32'(m_retry));
`ifdef WDT_RESET_CAUSE_EN
        check($sformatf("%s.cause", tag), 32'(cause), 32'(m_cause));
`endif
    endtask

    // Drive inputs after the previous edge, clock once, then compare 1 time unit later.
    task automatic step(input bit e, input bit c, input string tag);
        err = e;
        clr = c;
        @(posedge clk);
        model_step(e, c);
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check($sformatf("%s.sysrst", tag), 32'(sys_rst), 32'd1);
        check($sformatf("%s.restart", tag), 32'(restart), 32'd1);
        check($sformatf("%s.lockout", tag), 32'(lockout), 32'd0);
        check($sformatf("%s.retry", tag), 32'(retry), 32'd0);
`ifdef WDT_RESET_CAUSE_EN
        check($sformatf("%s.cause", tag), 32'(cause), 32'd0);
`endif
    endtask

    // Assert reset between edges and check outputs before any clock edge arrives.
    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals(tag);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        err   = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_reset_vals("por");
        model_reset();
        #9 rst_n = 1'b1;

        // Power-on pulse: high for exactly H cycles.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "t1_hold");
        check("t1_hold_hi", 32'(sys_rst), 32'd1);
        step(1'b0, 1'b0, "t1_hold");
        check("t1_hold_end", 32'(sys_rst), 32'd0);

        // Grace window, with an error in its third cycle that must be ignored.
        for (int i = 0; i < G; i++) step(i == 2, 1'b0, "t2_grace");
        step(1'b0, 1'b0, "t2_armed");
        step(1'b0, 1'b0, "t2_armed");

        // First error in ARMED: reset next cycle, count 1, H-cycle pulse.
        step(1'b1, 1'b0, "t3_err");
        check("t3_rst_hi", 32'(sys_rst), 32'd1);
        check("t3_count", 32'(retry), 32'd1);
        for (int i = 0; i < H - 1; i++) step(1'b0, 1'b0, "t3_hold");
        check("t3_hold_hi", 32'(sys_rst), 32'd1);
        step(1'b0, 1'b0, "t3_hold");
        check("t3_hold_end", 32'(sys_rst), 32'd0);

        // Error held across the end of GRACE is acted on in the first ARMED cycle -> LOCKOUT.
        for (int i = 0; i < G; i++) step(1'b1, 1'b0, "t4_grace");
        step(1'b1, 1'b0, "t4_err");
        check("t4_lockout", 32'(lockout), 32'd1);
        check("t4_count", 32'(retry), 32'd2);
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b0, "t4_lock");
        step(1'b0, 1'b1, "t4_clear");
        check("t4_clr_lockout", 32'(lockout), 32'd0);
        check("t4_clr_count", 32'(retry), 32'd0);
        check("t4_clr_rst", 32'(sys_rst), 32'd1);

        // Clear pulses outside LOCKOUT are ignored; one error then a stable run clears count.
        for (int i = 0; i < H + G; i++) step(1'b0, 1'(i % 2), "t5_boot");
        step(1'b1, 1'b0, "t5_err");
        for (int i = 0; i < H + G; i++) step(1'b0, 1'b1, "t5_boot2");
        for (int i = 0; i < S - 1; i++) step(1'b0, 1'b0, "t5_stable");
        check("t5_count_kept", 32'(retry), 32'd1);
        step(1'b0, 1'b0, "t5_stable");
        check("t5_count_clr", 32'(retry), 32'd0);

        // Error coinciding with stable expiry wins and still increments.
        step(1'b1, 1'b0, "t5b_err");
        for (int i = 0; i < H + G; i++) step(1'b0, 1'b0, "t5b_boot");
        for (int i = 0; i < S - 1; i++) step(1'b0, 1'b0, "t5b_stable");
        step(1'b1, 1'b0, "t5b_tie");
        check("t5b_tie_lockout", 32'(lockout), 32'd1);

        // Asynchronous reset mid-LOCKOUT, then mid-HOLD.
        async_reset("t6_lock_rst");
        step(1'b0, 1'b0, "t6_hold");
        step(1'b0, 1'b0, "t6_hold");
        async_reset("t6_hold_rst");

        // Randomised run against the model, with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0), "rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
